// File: rtl/mac_pkg.sv
// Shared types, default parameters and width/clip helpers for the
// pipelined multiply-accumulate block.
package mac_pkg;

  localparam int DEF_DWIDTH   = 8;
  localparam int DEF_ACC_LEN  = 4;
  localparam int DEF_OWIDTH   = 16;
  localparam int DEF_SATURATE = 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_e;

  typedef enum logic [1:0] {
    CLIP_NONE,
    CLIP_HI,
    CLIP_LO,
    CLIP_WRAP
  } clip_e;

  // Accumulator width large enough that acc_len full-scale products never overflow.
  function automatic int calc_awidth(input int dwidth, input int acc_len);
    return 2 * dwidth + $clog2(acc_len);
  endfunction

  // Classifies a sign-extended sum against the signed owidth-bit range.
  function automatic clip_e clip_kind(input logic signed [63:0] sum,
                                      input int owidth,
                                      input bit saturate);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (owidth - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (owidth - 1));
    if (sum > max_v) return saturate ? CLIP_HI : CLIP_WRAP;
    if (sum < min_v) return saturate ? CLIP_LO : CLIP_WRAP;
    return CLIP_NONE;
  endfunction

endpackage

// File: rtl/mac_sat_trunc.sv
// Combinational reduction of the wide accumulator sum to the output width,
// either clamping or wrapping, with a flag when the sum does not fit.
module mac_sat_trunc
  import mac_pkg::*;
#(
  parameter int AWIDTH   = 18,
  parameter int OWIDTH   = DEF_OWIDTH,
  parameter int SATURATE = DEF_SATURATE
) (
  input  logic signed [AWIDTH-1:0] sum_i,
  output logic signed [OWIDTH-1:0] p_o,
  output logic                     sat_o
);

  clip_e kind;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    kind  = clip_kind(64'(sum_i), OWIDTH, SATURATE != 0);
    p_o   = sum_i[OWIDTH-1:0];
    sat_o = (kind != CLIP_NONE);
    case (kind)
      CLIP_HI: p_o = {1'b0, {(OWIDTH-1){1'b1}}};
      CLIP_LO: p_o = {1'b1, {(OWIDTH-1){1'b0}}};
      default: ;
    endcase
  end

endmodule

// File: rtl/mac_acc_pipe.sv
// Two-stage signed multiply-accumulate: registered product, then a grouped
// accumulator that emits one clamped/truncated result every ACC_LEN operands.
module mac_acc_pipe
  import mac_pkg::*;
#(
  parameter int DWIDTH   = DEF_DWIDTH,
  parameter int ACC_LEN  = DEF_ACC_LEN,
  parameter int OWIDTH   = DEF_OWIDTH,
  parameter int SATURATE = DEF_SATURATE
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DWIDTH-1:0] a,
  input  logic signed [DWIDTH-1:0] b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OWIDTH-1:0] p,
  output logic                     sat
);

  localparam int AWIDTH = calc_awidth(DWIDTH, ACC_LEN);
  localparam int PWIDTH = 2 * DWIDTH;
  localparam int CWIDTH = $clog2(ACC_LEN);
  localparam logic [CWIDTH-1:0] LAST_CNT = CWIDTH'(ACC_LEN - 1);

  logic                     rdy_q;
  logic                     s1_valid_q, s1_valid_d;
  logic signed [PWIDTH-1:0] s1_prod_q, s1_prod_d;
  logic signed [AWIDTH-1:0] acc_q, acc_d;
  logic [CWIDTH-1:0]        cnt_q, cnt_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [OWIDTH-1:0] p_q, p_d;
  logic                     sat_q, sat_d;
  state_e                   state_q, state_d;

  logic                     stall, accept, xfer, fire, last;
  logic signed [AWIDTH-1:0] acc_sum;
  logic signed [OWIDTH-1:0] clip_p;
  logic                     clip_sat;

  mac_sat_trunc #(
    .AWIDTH  (AWIDTH),
    .OWIDTH  (OWIDTH),
    .SATURATE(SATURATE)
  ) u_sat_trunc (
    .sum_i(acc_sum),
    .p_o  (clip_p),
    .sat_o(clip_sat)
  );

  always_comb begin
    stall    = out_valid_q && !out_ready;
    in_ready = rdy_q && !stall;
    accept   = in_valid && in_ready;
    xfer     = out_valid_q && out_ready;
    fire     = s1_valid_q && !stall && !clr;
    last     = fire && (cnt_q == LAST_CNT);
    acc_sum  = acc_q + AWIDTH'(s1_prod_q);

    s1_valid_d  = s1_valid_q;
    s1_prod_d   = s1_prod_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    p_d         = p_q;
    sat_d       = sat_q;
    state_d     = state_q;

    // A stalled output freezes stage 1 as well, so nothing in flight is lost.
    if (!stall) begin
      s1_valid_d = accept && !clr;
      if (accept) s1_prod_d = PWIDTH'(a) * PWIDTH'(b);
    end

    if (xfer) out_valid_d = 1'b0;

    if (clr) begin
      s1_valid_d = 1'b0;
      acc_d      = '0;
      cnt_d      = '0;
    end else if (last) begin
      acc_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b1;
      p_d         = clip_p;
      sat_d       = clip_sat;
    end else if (fire) begin
      acc_d = acc_sum;
      cnt_d = cnt_q + CWIDTH'(1);
    end

    case (state_q)
      IDLE:    if (fire) state_d = ACCUM;
      ACCUM:   if (last) state_d = HOLD;
      HOLD:    if (xfer) state_d = fire ? ACCUM : IDLE;
      default: state_d = IDLE;
    endcase
    if (clr) state_d = out_valid_d ? HOLD : IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rdy_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_prod_q   <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      p_q         <= '0;
      sat_q       <= 1'b0;
      state_q     <= IDLE;
    end else begin
      rdy_q       <= 1'b1;
      s1_valid_q  <= s1_valid_d;
      s1_prod_q   <= s1_prod_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      p_q         <= p_d;
      sat_q       <= sat_d;
      state_q     <= state_d;
    end
  end

  assign out_valid = out_valid_q;
  assign p         = p_q;
  assign sat       = sat_q;

endmodule

// File: doc/mac_acc_pipe.md
MAC_ACC_PIPE -- requirements
Module: mac_acc_pipe

Interface
REQ-001 Parameter DWIDTH, default 8: signed operand width, at least 2.
REQ-002 Parameter ACC_LEN, default 4: products summed per result, at least 2.
REQ-003 Parameter OWIDTH, default 16: signed result width, at most AWIDTH.
REQ-004 Parameter SATURATE, default 1: 1 = clamp result, 0 = truncate result.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 aresetn  input  1  reset; asynchronous assertion, active-low.
REQ-007 clr  input  1  synchronous accumulation restart.
REQ-008 in_valid  input  1  operand pair valid.
REQ-009 in_ready  output  1  block accepts operand pair.
REQ-010 a  input  DWIDTH  signed operand A.
REQ-011 b  input  DWIDTH  signed operand B.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 p  output  OWIDTH  signed accumulated result.
REQ-015 sat  output  1  p was clamped or truncated (qualified by out_valid).

Function
REQ-016 Operand accept: in_valid && in_ready at a rising edge.
REQ-017 Result transfer: out_valid && out_ready at a rising edge.
REQ-018 in_ready = !(out_valid && !out_ready); a stall freezes the entire pipeline.
REQ-019 Stage 1: accepted a*b registered as a full-precision signed product (2*DWIDTH bits).
REQ-020 Stage 2: product added to an accumulator of AWIDTH = 2*DWIDTH + $clog2(ACC_LEN) bits.
  - Accumulator never overflows internally.
REQ-021 FSM states:
  - IDLE: count 0, accumulator 0.
  - ACCUM: 1..ACC_LEN-1 products summed.
  - HOLD: result pending at output.
REQ-022 IDLE->ACCUM on the first product reaching stage 2.
REQ-023 On the ACC_LEN-th product, the output register loads the final sum and out_valid rises.
  - Accumulator and count restart at 0 in the same cycle; FSM -> HOLD.
REQ-024 HOLD->ACCUM when the result transfers and the next product arrives in that same cycle.
  - HOLD->IDLE when the result transfers with no product.
  - A new group's first product while out_valid is high but transferring is accumulated without a bubble.
REQ-025 Latency: the ACC_LEN-th operand accepted at cycle N -> out_valid high at cycle N+2.
  - Sustained throughput is one operand per cycle with out_ready held high.
REQ-026 p and sat stay stable while out_valid && !out_ready.
REQ-027 SATURATE=1, sum > 2^(OWIDTH-1)-1: p = 2^(OWIDTH-1)-1, sat = 1.
  - Sum < -2^(OWIDTH-1): p = -2^(OWIDTH-1), sat = 1.
  - Otherwise p = sum, sat = 0.
REQ-028 SATURATE=0: p = sum[OWIDTH-1:0]; sat = 1 iff the sum is not representable in OWIDTH bits.
REQ-029 clr=1: accumulator, count and stage-1 valid cleared next edge; FSM -> IDLE unless out_valid is held.
  - Pending output result is unaffected.
  - An operand accepted in the clr cycle is discarded.
REQ-030 clr takes priority over a simultaneous ACC_LEN-th product: no result is produced.
REQ-031 in_valid low mid-group leaves a gap; partial sum and count are held indefinitely.

Reset
REQ-032 aresetn low clears asynchronously:
  - out_valid=0, p=0, sat=0, in_ready=0;
  - accumulator=0, count=0, stage-1 valid=0;
  - FSM=IDLE.
REQ-033 in_ready rises on the first rising edge after aresetn deasserts.
REQ-034 Reset mid-group discards the partial sum and any in-flight product; no spurious out_valid after release.

Structure
REQ-035 Shared package mac_pkg holds:
  - FSM state enum (IDLE, ACCUM, HOLD);
  - AWIDTH computation function;
  - saturate/truncate function;
  - default parameter constants.
REQ-036 One sub-module, mac_sat_trunc: combinational AWIDTH->OWIDTH clamp/truncate with sat flag, parametrised by SATURATE.
REQ-037 Multiplier, accumulator, FSM and handshake live in mac_acc_pipe.

Verification (DWIDTH=8, ACC_LEN=4, OWIDTH=16 unless stated)
REQ-038 Sum: a=3, b=4 four cycles back-to-back, out_ready=1 -> p=48, sat=0, out_valid 2 cycles after the 4th accept.
REQ-039 Saturate: a=-128, b=-128 x4 -> SATURATE=1: p=32767, sat=1; SATURATE=0: p=0, sat=1.
REQ-040 Negative clamp: a=-128, b=127 x4 (sum -65024) -> SATURATE=1: p=-32768, sat=1.
REQ-041 Backpressure: 8 pairs a=1, b=1 back-to-back, out_ready=0 for 5 cycles after first out_valid.
  - in_ready low during the stall, p=4 held;
  - two results of 4, no operand lost.
REQ-042 clr: clr after 2 of a=5, b=5, then 4 pairs a=2, b=2 -> single result p=16.
REQ-043 Reset: aresetn pulsed low after 3 pairs -> out_valid=0, p=0 immediately.
  - Next 4 pairs a=1, b=2 -> p=8.
